// File: rtl/set_compare_seq.sv
// Digit-serial compare-and-set unit: subtracts a - b one DIGIT-bit chunk per
// cycle, LSB first, and turns the final Z/N/V/C flags into a set-instruction result.
module set_compare_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t          state, state_nxt;
    req_t            req;
    logic            carry, nz;
    logic [IW-1:0]   idx;
    logic            accept;
    logic [DIGIT:0]  sum;
    logic [DIGIT-1:0] d;
    logic            c_out, c_msb_in, f_z, f_lt, f_ltu, flag;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (idx == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands shift right each chunk, so the active digit is always in the low bits.
    always_comb begin
        sum      = {1'b0, req.a[DIGIT-1:0]} + {1'b0, ~req.b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        d        = sum[DIGIT-1:0];
        c_out    = sum[DIGIT];
        c_msb_in = req.a[DIGIT-1] ^ ~req.b[DIGIT-1] ^ d[DIGIT-1];
        f_z      = ~(nz | (|d));
        f_lt     = d[DIGIT-1] ^ (c_msb_in ^ c_out);
        f_ltu    = ~c_out;
        flag     = 1'b0;
        case (req.op)
            3'd0: flag = f_z;
            3'd1: flag = ~f_z;
            3'd2: flag = f_lt;
            3'd3: flag = ~f_lt & ~f_z;
            3'd4: flag = f_lt | f_z;
            3'd5: flag = ~f_lt;
            3'd6: flag = f_ltu;
            3'd7: flag = ~f_ltu;
            default: flag = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req    <= '0;
            carry  <= 1'b0;
            nz     <= 1'b0;
            idx    <= '0;
            result <= '0;
            zf     <= 1'b0;
        end else if (accept) begin
            req   <= '{op: op, a: in_a, b: in_b};
            carry <= 1'b1;
            nz    <= 1'b0;
            idx   <= '0;
        end else if (state == S_RUN) begin
            req.a <= req.a >> DIGIT;
            req.b <= req.b >> DIGIT;
            carry <= c_out;
            nz    <= nz | (|d);
            idx   <= idx + IW'(1);
            // Final chunk: flags are fully formed, publish the result on this edge.
            if (idx == LAST) begin
                result <= {{(WIDTH-1){1'b0}}, flag};
                zf     <= f_z;
            end
        end
    end
endmodule
